rng_link_monitor: RTL

- Host-side counterpart of the random-byte UART streamer.
- Drives a uart instance's byte interface.
- Sends the 'r' (0x72) reset command to the generator, discards the first bytes, then collects SAMPLE_BYTES random bytes.
- Runs a monobit (ones-count) health check on the collected bytes and reports pass, fail or timeout.
- Used on a second board, or in loopback, to qualify the ring-oscillator RNG link.

---
 rtl/rng_link_monitor.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/rng_link_monitor.sv
// Host-side monitor for the random-byte UART streamer: issues the 'r' reseed command,
// drops the first bytes, then runs a monobit ones-count check over the sampled stream.
module rng_link_monitor #(
   parameter  int SAMPLE_BYTES   = 256,
   parameter  int DISCARD_BYTES  = 2,
   parameter  int TIMEOUT_CYCLES = 1200000,
   parameter  int ONES_MIN       = 960,
   parameter  int ONES_MAX       = 1088,
   localparam int CW             = $clog2(SAMPLE_BYTES * 8 + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          uart_is_transmitting,
   input  logic          uart_received,
   input  logic [7:0]    uart_rx_byte,
   output logic          uart_transmit,
   output logic [7:0]    uart_tx_byte,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic          timeout,
   output logic [CW-1:0] ones_count
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int BW = $clog2(SAMPLE_BYTES + 1);
   localparam int DW = (DISCARD_BYTES > 0) ? $clog2(DISCARD_BYTES + 1) : 1;

   localparam logic [TW-1:0] TMO_LAST     = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] TMO_MAX      = TW'(TIMEOUT_CYCLES);
   localparam logic [BW-1:0] BYTE_LAST    = BW'(SAMPLE_BYTES - 1);
   localparam logic [DW-1:0] DISCARD_INIT = DW'(DISCARD_BYTES);
   localparam logic [CW-1:0] ONES_LO      = CW'(ONES_MIN);
   localparam logic [CW-1:0] ONES_HI      = CW'(ONES_MAX);

   typedef enum logic [2:0] {IDLE, SEND, WAIT_TX, COLLECT, DONE} state_t;

   state_t        state;
   logic [TW-1:0] tmo_cnt;
   logic [BW-1:0] byte_cnt;
   logic [DW-1:0] discard_cnt;
   logic          rise_seen;
   logic [CW-1:0] ones_next;

   function automatic logic [3:0] popcount8(input logic [7:0] b);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) n = n + {3'b000, b[i]};
      return n;
   endfunction

   assign ones_next    = ones_count + CW'(popcount8(uart_rx_byte));
   assign uart_tx_byte = 8'h72;
   assign busy         = (state == SEND) || (state == WAIT_TX) || (state == COLLECT);

   // NOTE: every register here is assigned with <= so all of them update from the
   // same pre-edge snapshot; a blocking assignment would leak new values into later reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         uart_transmit <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         timeout       <= 1'b0;
         ones_count    <= '0;
         tmo_cnt       <= '0;
         byte_cnt      <= '0;
         discard_cnt   <= '0;
         rise_seen     <= 1'b0;
      end else begin
         uart_transmit <= 1'b0;
         done          <= 1'b0;
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  state       <= SEND;
                  ones_count  <= '0;
                  pass        <= 1'b0;
                  timeout     <= 1'b0;
                  tmo_cnt     <= '0;
                  byte_cnt    <= '0;
                  rise_seen   <= 1'b0;
                  discard_cnt <= DISCARD_INIT;
               end
            end
            SEND: begin
               if (!uart_is_transmitting) begin
                  uart_transmit <= 1'b1;
                  tmo_cnt       <= '0;
                  rise_seen     <= 1'b0;
                  state         <= WAIT_TX;
               end
            end
            WAIT_TX: begin
               // Busy was low when the command left SEND, so any high level here is the rise.
               if (rise_seen && !uart_is_transmitting) begin
                  tmo_cnt <= '0;
                  state   <= COLLECT;
               end else if (tmo_cnt == TMO_LAST) begin
                  tmo_cnt <= TMO_MAX;
                  timeout <= 1'b1;
                  pass    <= 1'b0;
                  done    <= 1'b1;
                  state   <= DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
                  if (uart_is_transmitting) rise_seen <= 1'b1;
               end
            end
            COLLECT: begin
               // A byte arriving on the expiry cycle takes priority over the timeout.
               if (uart_received) begin
                  tmo_cnt <= '0;
                  if (discard_cnt != '0) begin
                     discard_cnt <= discard_cnt - 1'b1;
                  end else begin
                     ones_count <= ones_next;
                     byte_cnt   <= byte_cnt + 1'b1;
                     if (byte_cnt == BYTE_LAST) begin
                        pass  <= (ones_next >= ONES_LO) && (ones_next <= ONES_HI);
                        done  <= 1'b1;
                        state <= DONE;
                     end
                  end
               end else if (tmo_cnt == TMO_LAST) begin
                  tmo_cnt <= TMO_MAX;
                  timeout <= 1'b1;
                  pass    <= 1'b0;
                  done    <= 1'b1;
                  state   <= DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
